// File: rtl/ocp_fabric_2m5s.sv
// ocp_fabric_2m5s: OCP interconnect joining the CPU instruction (I) and data (D)
// master ports to five slave ports (memory, UART, sim ctl, intr ctl, timer).
//
// Handshake: a master presents a non-IDLE MCmd and holds MAddr/MCmd/MData/MByteEn
// stable until it sees SCmdAccept=1 in the same cycle; that cycle is the transfer.
// The fabric never buffers a command, so forwarding is purely combinational and
// SCmdAccept is the granted slave's accept. A read leaves the master "pending" on
// its port until the slave returns a non-NULL SResp, which is steered back only
// to that master.
module ocp_fabric_2m5s #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BEN_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  // instruction master
  input  logic [ADDR_WIDTH-1:0] i_I_MAddr,
  input  logic [2:0]            i_I_MCmd,
  input  logic [DATA_WIDTH-1:0] i_I_MData,
  input  logic [BEN_WIDTH-1:0]  i_I_MByteEn,
  output logic                  o_I_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_I_SData,
  output logic [1:0]            o_I_SResp,
  // data master
  input  logic [ADDR_WIDTH-1:0] i_D_MAddr,
  input  logic [2:0]            i_D_MCmd,
  input  logic [DATA_WIDTH-1:0] i_D_MData,
  input  logic [BEN_WIDTH-1:0]  i_D_MByteEn,
  output logic                  o_D_SCmdAccept,
  output logic [DATA_WIDTH-1:0] o_D_SData,
  output logic [1:0]            o_D_SResp,
  // port 0: memory
  output logic [ADDR_WIDTH-1:0] o_P0_MAddr,
  output logic [2:0]            o_P0_MCmd,
  output logic [DATA_WIDTH-1:0] o_P0_MData,
  output logic [BEN_WIDTH-1:0]  o_P0_MByteEn,
  input  logic                  i_P0_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P0_SData,
  input  logic [1:0]            i_P0_SResp,
  // port 1: UART
  output logic [ADDR_WIDTH-1:0] o_P1_MAddr,
  output logic [2:0]            o_P1_MCmd,
  output logic [DATA_WIDTH-1:0] o_P1_MData,
  output logic [BEN_WIDTH-1:0]  o_P1_MByteEn,
  input  logic                  i_P1_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P1_SData,
  input  logic [1:0]            i_P1_SResp,
  // port 2: sim ctl
  output logic [ADDR_WIDTH-1:0] o_P2_MAddr,
  output logic [2:0]            o_P2_MCmd,
  output logic [DATA_WIDTH-1:0] o_P2_MData,
  output logic [BEN_WIDTH-1:0]  o_P2_MByteEn,
  input  logic                  i_P2_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P2_SData,
  input  logic [1:0]            i_P2_SResp,
  // port 3: interrupt controller
  output logic [ADDR_WIDTH-1:0] o_P3_MAddr,
  output logic [2:0]            o_P3_MCmd,
  output logic [DATA_WIDTH-1:0] o_P3_MData,
  output logic [BEN_WIDTH-1:0]  o_P3_MByteEn,
  input  logic                  i_P3_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P3_SData,
  input  logic [1:0]            i_P3_SResp,
  // port 4: timer
  output logic [ADDR_WIDTH-1:0] o_P4_MAddr,
  output logic [2:0]            o_P4_MCmd,
  output logic [DATA_WIDTH-1:0] o_P4_MData,
  output logic [BEN_WIDTH-1:0]  o_P4_MByteEn,
  input  logic                  i_P4_SCmdAccept,
  input  logic [DATA_WIDTH-1:0] i_P4_SData,
  input  logic [1:0]            i_P4_SResp
);

  localparam logic [2:0] CMD_IDLE      = 3'd0;
  localparam logic [2:0] CMD_READ      = 3'd2;
  localparam logic [1:0] RESP_NULL     = 2'd0;
  localparam logic [1:0] RESP_ERR      = 2'd3;
  // Port index 5 is the virtual "unmapped" target; it always accepts.
  localparam logic [2:0] PORT_UNMAPPED = 3'd5;

  // Address decode: low half is memory, then 1 MB windows for the peripherals.
  function automatic logic [2:0] decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [2:0] p;
    p = PORT_UNMAPPED;
    if (!addr[ADDR_WIDTH-1]) begin
      p = 3'd0;
    end else begin
      case (addr[ADDR_WIDTH-1:ADDR_WIDTH-12])
        12'h800: p = 3'd1;
        12'h801: p = 3'd2;
        12'h802: p = 3'd3;
        12'h803: p = 3'd4;
        default: p = PORT_UNMAPPED;
      endcase
    end
    return p;
  endfunction

  // Master-side views: index 0 = I, index 1 = D.
  logic [ADDR_WIDTH-1:0] m_addr [2];
  logic [2:0]            m_cmd  [2];
  logic [DATA_WIDTH-1:0] m_data [2];
  logic [BEN_WIDTH-1:0]  m_ben  [2];

  assign m_addr[0] = i_I_MAddr;   assign m_addr[1] = i_D_MAddr;
  assign m_cmd[0]  = i_I_MCmd;    assign m_cmd[1]  = i_D_MCmd;
  assign m_data[0] = i_I_MData;   assign m_data[1] = i_D_MData;
  assign m_ben[0]  = i_I_MByteEn; assign m_ben[1]  = i_D_MByteEn;

  // Slave-side views.
  logic [7:0]            port_accept;
  logic [DATA_WIDTH-1:0] p_sdata [5];
  logic [1:0]            p_sresp [5];

  assign port_accept = {3'b111, i_P4_SCmdAccept, i_P3_SCmdAccept, i_P2_SCmdAccept,
                        i_P1_SCmdAccept, i_P0_SCmdAccept};
  assign p_sdata[0] = i_P0_SData; assign p_sresp[0] = i_P0_SResp;
  assign p_sdata[1] = i_P1_SData; assign p_sresp[1] = i_P1_SResp;
  assign p_sdata[2] = i_P2_SData; assign p_sresp[2] = i_P2_SResp;
  assign p_sdata[3] = i_P3_SData; assign p_sresp[3] = i_P3_SResp;
  assign p_sdata[4] = i_P4_SData; assign p_sresp[4] = i_P4_SResp;

  // Outstanding-read tracking per master; the pending master owns its port.
  logic [1:0] pend_q, pend_d;
  logic [2:0] port_q [2];
  logic [2:0] port_d [2];

  logic [2:0] sel [2];
  logic [1:0] ok, grant, acc;

  // Arbitration: only registered ownership gates a request, so a slave response
  // can never reach another port's MCmd combinationally.
  always_comb begin
    sel[0] = decode(m_addr[0]);
    sel[1] = decode(m_addr[1]);
    ok[0]  = !rst && (m_cmd[0] != CMD_IDLE) && !pend_q[0] &&
             !(pend_q[1] && (port_q[1] == sel[0]) && (sel[0] != PORT_UNMAPPED));
    ok[1]  = !rst && (m_cmd[1] != CMD_IDLE) && !pend_q[1] &&
             !(pend_q[0] && (port_q[0] == sel[1]) && (sel[1] != PORT_UNMAPPED));
    grant[1] = ok[1];
    grant[0] = ok[0] && !(ok[1] && (sel[1] == sel[0]) && (sel[0] != PORT_UNMAPPED));
    acc[0]   = grant[0] && port_accept[sel[0]];
    acc[1]   = grant[1] && port_accept[sel[1]];
  end

  logic [ADDR_WIDTH-1:0] f_addr [5];
  logic [2:0]            f_cmd  [5];
  logic [DATA_WIDTH-1:0] f_data [5];
  logic [BEN_WIDTH-1:0]  f_ben  [5];

  // Command forwarding: the granted master drives its port, all others see IDLE/zero.
  always_comb begin
    for (int n = 0; n < 5; n++) begin
      f_addr[n] = '0;
      f_cmd[n]  = CMD_IDLE;
      f_data[n] = '0;
      f_ben[n]  = '0;
      if (grant[1] && (sel[1] == 3'(n))) begin
        f_addr[n] = m_addr[1];
        f_cmd[n]  = m_cmd[1];
        f_data[n] = m_data[1];
        f_ben[n]  = m_ben[1];
      end else if (grant[0] && (sel[0] == 3'(n))) begin
        f_addr[n] = m_addr[0];
        f_cmd[n]  = m_cmd[0];
        f_data[n] = m_data[0];
        f_ben[n]  = m_ben[0];
      end
    end
  end

  logic [1:0]            rsp_resp [2];
  logic [DATA_WIDTH-1:0] rsp_data [2];

  // Response routing: a pending master listens only to its own port; an unmapped
  // read answers ERR in the first cycle after acceptance.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      rsp_resp[m] = RESP_ERR;
      rsp_data[m] = '0;
      for (int n = 0; n < 5; n++) begin
        if (port_q[m] == 3'(n)) begin
          rsp_resp[m] = p_sresp[n];
          rsp_data[m] = p_sdata[n];
        end
      end
      if (rst || !pend_q[m]) begin
        rsp_resp[m] = RESP_NULL;
        rsp_data[m] = '0;
      end
    end
  end

  // Pending-read next state: set on an accepted read, clear on its response.
  always_comb begin
    for (int m = 0; m < 2; m++) begin
      pend_d[m] = pend_q[m];
      port_d[m] = port_q[m];
      if (pend_q[m] && (rsp_resp[m] != RESP_NULL)) pend_d[m] = 1'b0;
      if (acc[m] && (m_cmd[m] == CMD_READ)) begin
        pend_d[m] = 1'b1;
        port_d[m] = sel[m];
      end
    end
  end

  // Pending-read registers; reset abandons any outstanding read.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q    <= '0;
      port_q[0] <= '0;
      port_q[1] <= '0;
    end else begin
      pend_q    <= pend_d;
      port_q[0] <= port_d[0];
      port_q[1] <= port_d[1];
    end
  end

  assign o_I_SCmdAccept = acc[0];
  assign o_I_SResp      = rsp_resp[0];
  assign o_I_SData      = rsp_data[0];
  assign o_D_SCmdAccept = acc[1];
  assign o_D_SResp      = rsp_resp[1];
  assign o_D_SData      = rsp_data[1];

  assign o_P0_MAddr = f_addr[0]; assign o_P0_MCmd = f_cmd[0];
  assign o_P0_MData = f_data[0]; assign o_P0_MByteEn = f_ben[0];
  assign o_P1_MAddr = f_addr[1]; assign o_P1_MCmd = f_cmd[1];
  assign o_P1_MData = f_data[1]; assign o_P1_MByteEn = f_ben[1];
  assign o_P2_MAddr = f_addr[2]; assign o_P2_MCmd = f_cmd[2];
  assign o_P2_MData = f_data[2]; assign o_P2_MByteEn = f_ben[2];
  assign o_P3_MAddr = f_addr[3]; assign o_P3_MCmd = f_cmd[3];
  assign o_P3_MData = f_data[3]; assign o_P3_MByteEn = f_ben[3];
  assign o_P4_MAddr = f_addr[4]; assign o_P4_MCmd = f_cmd[4];
  assign o_P4_MData = f_data[4]; assign o_P4_MByteEn = f_ben[4];

endmodule

// File: tb/tb_ocp_fabric_2m5s.sv
// tb_ocp_fabric_2m5s: drives both masters against five register-file slave models
// (random accept stalls, 1..3 cycle read latency) and scoreboards the routed responses.
module tb_ocp_fabric_2m5s;

  localparam int W = 34;  // {SResp, SData}
  localparam logic [2:0] IDLE = 3'd0, WR = 3'd1, RD = 3'd2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // ---------------- DUT wiring (index 0 = I, 1 = D) ----------------
  logic [31:0] m_addr [2];
  logic [2:0]  m_cmd  [2];
  logic [31:0] m_data [2];
  logic [3:0]  m_ben  [2];
  logic        m_acc  [2];
  logic [31:0] m_sdata[2];
  logic [1:0]  m_sresp[2];

  logic [31:0] p_maddr[5];
  logic [2:0]  p_mcmd [5];
  logic [31:0] p_mdata[5];
  logic [3:0]  p_mben [5];
  logic        p_acc  [5];
  logic [31:0] p_sdata[5];
  logic [1:0]  p_sresp[5];

  ocp_fabric_2m5s dut (
    .clk(clk), .rst(rst),
    .i_I_MAddr(m_addr[0]), .i_I_MCmd(m_cmd[0]), .i_I_MData(m_data[0]), .i_I_MByteEn(m_ben[0]),
    .o_I_SCmdAccept(m_acc[0]), .o_I_SData(m_sdata[0]), .o_I_SResp(m_sresp[0]),
    .i_D_MAddr(m_addr[1]), .i_D_MCmd(m_cmd[1]), .i_D_MData(m_data[1]), .i_D_MByteEn(m_ben[1]),
    .o_D_SCmdAccept(m_acc[1]), .o_D_SData(m_sdata[1]), .o_D_SResp(m_sresp[1]),
    .o_P0_MAddr(p_maddr[0]), .o_P0_MCmd(p_mcmd[0]), .o_P0_MData(p_mdata[0]), .o_P0_MByteEn(p_mben[0]),
    .i_P0_SCmdAccept(p_acc[0]), .i_P0_SData(p_sdata[0]), .i_P0_SResp(p_sresp[0]),
    .o_P1_MAddr(p_maddr[1]), .o_P1_MCmd(p_mcmd[1]), .o_P1_MData(p_mdata[1]), .o_P1_MByteEn(p_mben[1]),
    .i_P1_SCmdAccept(p_acc[1]), .i_P1_SData(p_sdata[1]), .i_P1_SResp(p_sresp[1]),
    .o_P2_MAddr(p_maddr[2]), .o_P2_MCmd(p_mcmd[2]), .o_P2_MData(p_mdata[2]), .o_P2_MByteEn(p_mben[2]),
    .i_P2_SCmdAccept(p_acc[2]), .i_P2_SData(p_sdata[2]), .i_P2_SResp(p_sresp[2]),
    .o_P3_MAddr(p_maddr[3]), .o_P3_MCmd(p_mcmd[3]), .o_P3_MData(p_mdata[3]), .o_P3_MByteEn(p_mben[3]),
    .i_P3_SCmdAccept(p_acc[3]), .i_P3_SData(p_sdata[3]), .i_P3_SResp(p_sresp[3]),
    .o_P4_MAddr(p_maddr[4]), .o_P4_MCmd(p_mcmd[4]), .o_P4_MData(p_mdata[4]), .o_P4_MByteEn(p_mben[4]),
    .i_P4_SCmdAccept(p_acc[4]), .i_P4_SData(p_sdata[4]), .i_P4_SResp(p_sresp[4])
  );

  // ---------------- reference model ----------------
  int vectors = 0;
  int errors  = 0;
  logic [W-1:0] exp_q_i[$];
  logic [W-1:0] exp_q_d[$];
  logic [31:0]  ref_mem [logic [31:0]];
  int resp_cyc [2];

  function automatic int tb_port(input logic [31:0] a);
    if (a < 32'h8000_0000) return 0;
    if (a < 32'h8010_0000) return 1;
    if (a < 32'h8020_0000) return 2;
    if (a < 32'h8030_0000) return 3;
    if (a < 32'h8040_0000) return 4;
    return 5;
  endfunction

  function automatic logic [31:0] port_base(input int n);
    if (n == 0) return 32'h0;
    return 32'h8000_0000 + 32'((n - 1) * 32'h0010_0000);
  endfunction

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'h1357_9BDC;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (ref_mem.exists(k)) return ref_mem[k];
    return init_word(k);
  endfunction

  // ---------------- slave models ----------------
  logic [31:0] smem [5][16];
  int          rsp_wait [5];
  logic [31:0] rsp_val  [5];
  bit          stall_en = 1'b0;
  int          lat_lo = 1, lat_hi = 3;

  // Handshakes are settled mid-cycle, so this sees the transfer that completes at the next edge.
  always @(negedge clk) begin
    for (int n = 0; n < 5; n++) begin
      if (!rst && p_mcmd[n] != IDLE && p_acc[n]) begin
        if (p_mcmd[n] == WR)
          smem[n][p_maddr[n][5:2]] = merge(smem[n][p_maddr[n][5:2]], p_mdata[n], p_mben[n]);
        else if (p_mcmd[n] == RD) begin
          rsp_val[n]  = smem[n][p_maddr[n][5:2]];
          rsp_wait[n] = $urandom_range(lat_hi, lat_lo);
        end
      end
    end
  end

  // Slave outputs change just after the edge.
  always @(posedge clk) begin
    #1;
    for (int n = 0; n < 5; n++) begin
      p_sresp[n] = 2'd0;
      p_sdata[n] = 32'h0;
      if (rsp_wait[n] > 0) begin
        rsp_wait[n]--;
        if (rsp_wait[n] == 0) begin
          p_sresp[n] = 2'd1;
          p_sdata[n] = rsp_val[n];
        end
      end
      p_acc[n] = stall_en ? ($urandom_range(2, 0) != 0) : 1'b1;
    end
  end

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (m_sresp[m] != 2'd0) begin
        logic [W-1:0] got, exp;
        resp_cyc[m] = cyc;
        got = {m_sresp[m], m_sdata[m]};
        vectors++;
        if ((m == 0 && exp_q_i.size() == 0) || (m == 1 && exp_q_d.size() == 0)) begin
          errors++;
          $display("FAIL unexpected_resp master=%0d got=%h required=no response", m, got);
        end else begin
          exp = (m == 0) ? exp_q_i.pop_front() : exp_q_d.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL read_resp master=%0d got=%h required=%h", m, got, exp);
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Call at posedge+1; returns at posedge+1 after the accepting cycle.
  task automatic master_op(input int m, input logic [2:0] cmd, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] be, output int acc_cyc);
    int n = 0;
    bit done = 1'b0;
    m_addr[m] = addr; m_cmd[m] = cmd; m_data[m] = data; m_ben[m] = be;
    acc_cyc = -1;
    while (!done) begin
      @(negedge clk);
      if (m_acc[m]) begin
        done = 1'b1;
        acc_cyc = cyc;
        if (cmd == RD) begin
          logic [W-1:0] e;
          e = (tb_port(addr) == 5) ? {2'd3, 32'h0} : {2'd1, ref_read(addr)};
          if (m == 0) exp_q_i.push_back(e); else exp_q_d.push_back(e);
        end else if (tb_port(addr) != 5) begin
          ref_mem[{addr[31:2], 2'b00}] = merge(ref_read(addr), data, be);
        end
      end else if (++n > 200) begin
        done = 1'b1;
        vectors++;
        errors++;
        $display("FAIL accept_timeout master=%0d addr=%h got=no accept required=accept", m, addr);
      end
      @(posedge clk); #1;
    end
    m_cmd[m] = IDLE; m_addr[m] = 32'h0; m_data[m] = 32'h0; m_ben[m] = 4'h0;
  endtask

  task automatic idle_cycles(input int k);
    repeat (k) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain;
    int n = 0;
    while ((exp_q_i.size() != 0 || exp_q_d.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (exp_q_i.size() != 0 || exp_q_d.size() != 0) begin
      errors++;
      $display("FAIL drain pending_i=%0d pending_d=%0d required=0", exp_q_i.size(), exp_q_d.size());
      exp_q_i.delete();
      exp_q_d.delete();
    end
    idle_cycles(2);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1;
    m_cmd[0] = RD; m_addr[0] = 32'h0;         m_ben[0] = 4'hF;
    m_cmd[1] = WR; m_addr[1] = 32'h8000_0000; m_ben[1] = 4'hF; m_data[1] = 32'h21;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int m = 0; m < 2; m++) begin
      vectors += 3;
      if (m_acc[m] !== 1'b0) begin
        errors++; $display("FAIL reset_accept master=%0d got=%b required=0", m, m_acc[m]);
      end
      if (m_sresp[m] !== 2'd0) begin
        errors++; $display("FAIL reset_sresp master=%0d got=%0d required=0", m, m_sresp[m]);
      end
      if (m_sdata[m] !== 32'h0) begin
        errors++; $display("FAIL reset_sdata master=%0d got=%h required=0", m, m_sdata[m]);
      end
    end
    for (int n = 0; n < 5; n++) begin
      vectors++;
      if (p_mcmd[n] !== IDLE) begin
        errors++; $display("FAIL reset_mcmd port=%0d got=%0d required=0", n, p_mcmd[n]);
      end
    end
    @(posedge clk); #1;
    for (int m = 0; m < 2; m++) begin
      m_cmd[m] = IDLE; m_addr[m] = 32'h0; m_data[m] = 32'h0; m_ben[m] = 4'h0;
    end
    rst = 1'b0;
    idle_cycles(1);
  endtask

  task automatic test_owner_block;
    int a_i, a_d;
    stall_en = 1'b0;
    fork
      master_op(0, RD, 32'h0, 32'h0, 4'hF, a_i);
      begin
        idle_cycles(1);
        master_op(1, WR, 32'h0, 32'hDEAD_BEEF, 4'hF, a_d);
      end
    join
    wait_drain();
    vectors++;
    if (a_d != resp_cyc[0] + 1) begin
      errors++;
      $display("FAIL owner_block d_accept_cyc=%0d required=%0d", a_d, resp_cyc[0] + 1);
    end
    master_op(1, RD, 32'h0, 32'h0, 4'hF, a_d);
    wait_drain();
  endtask

  task automatic test_same_port_priority;
    int a_i, a_d, start;
    stall_en = 1'b0;
    start = cyc;
    fork
      master_op(0, RD, 32'h0, 32'h0, 4'hF, a_i);
      master_op(1, RD, 32'h4, 32'h0, 4'hF, a_d);
    join
    wait_drain();
    vectors += 2;
    if (a_d != start) begin
      errors++; $display("FAIL d_priority d_accept_cyc=%0d required=%0d", a_d, start);
    end
    if (a_i != resp_cyc[1] + 1) begin
      errors++; $display("FAIL i_waits i_accept_cyc=%0d required=%0d", a_i, resp_cyc[1] + 1);
    end
  endtask

  task automatic test_parallel_ports;
    int a_i, a_d, start;
    stall_en = 1'b0;
    start = cyc;
    fork
      master_op(0, WR, 32'h8, 32'h5A5A_5A5A, 4'hF, a_i);
      master_op(1, WR, 32'h8000_0000, 32'h21, 4'hF, a_d);
    join
    vectors += 2;
    if (a_i != start) begin
      errors++; $display("FAIL parallel_i accept_cyc=%0d required=%0d", a_i, start);
    end
    if (a_d != start) begin
      errors++; $display("FAIL parallel_d accept_cyc=%0d required=%0d", a_d, start);
    end
    fork
      master_op(0, RD, 32'h8, 32'h0, 4'hF, a_i);
      master_op(1, RD, 32'h8000_0000, 32'h0, 4'hF, a_d);
    join
    wait_drain();
  endtask

  task automatic test_timer_ic;
    int a;
    stall_en = 1'b1;
    master_op(1, WR, 32'h8030_0004, 32'h10, 4'hF, a);
    master_op(0, WR, 32'h8030_0000, 32'h7, 4'hF, a);
    master_op(1, WR, 32'h8020_0004, 32'h1, 4'hF, a);
    master_op(1, WR, 32'h0000_0010, 32'h1122_3344, 4'b0101, a);
    master_op(1, RD, 32'h8020_0004, 32'h0, 4'hF, a);
    master_op(0, RD, 32'h8030_0000, 32'h0, 4'hF, a);
    master_op(0, RD, 32'h0000_0010, 32'h0, 4'hF, a);
    wait_drain();
  endtask

  task automatic test_cross_read;
    stall_en = 1'b0;
    for (int first = 0; first < 2; first++) begin
      int a_f, a_s;
      fork
        master_op(first, RD, 32'h8030_0004, 32'h0, 4'hF, a_f);
        begin
          idle_cycles(1);
          master_op(1 - first, RD, 32'h8030_0004, 32'h0, 4'hF, a_s);
        end
      join
      wait_drain();
      vectors++;
      if (a_s != resp_cyc[first] + 1) begin
        errors++;
        $display("FAIL cross_stall first=%0d second_accept_cyc=%0d required=%0d",
                 first, a_s, resp_cyc[first] + 1);
      end
    end
  endtask

  task automatic test_unmapped;
    int a, a2, start;
    stall_en = 1'b1;
    start = cyc;
    master_op(1, RD, 32'h9000_0000, 32'h0, 4'hF, a);
    wait_drain();
    vectors += 2;
    if (a != start) begin
      errors++; $display("FAIL unmapped_accept accept_cyc=%0d required=%0d", a, start);
    end
    if (resp_cyc[1] != a + 1) begin
      errors++; $display("FAIL unmapped_latency resp_cyc=%0d required=%0d", resp_cyc[1], a + 1);
    end
    start = cyc;
    master_op(0, WR, 32'hA000_0000, 32'hCAFE_F00D, 4'hF, a2);
    vectors++;
    if (a2 != start) begin
      errors++; $display("FAIL unmapped_wr_accept accept_cyc=%0d required=%0d", a2, start);
    end
    master_op(0, RD, 32'hA000_0000, 32'h0, 4'hF, a2);
    wait_drain();
  endtask

  task automatic test_random;
    logic [31:0] pool [8];
    pool = '{32'h0, 32'h4, 32'h3C, 32'h8000_0008, 32'h8010_0010,
             32'h8020_0004, 32'h8030_0004, 32'h9000_0000};
    stall_en = 1'b1;
    fork
      for (int k = 0; k < 40; k++) begin
        int a;
        idle_cycles($urandom_range(2, 0));
        master_op(0, ($urandom_range(1, 0) != 0) ? RD : WR, pool[$urandom_range(7, 0)],
                  $urandom, 4'($urandom_range(15, 1)), a);
      end
      for (int k = 0; k < 40; k++) begin
        int a;
        idle_cycles($urandom_range(2, 0));
        master_op(1, ($urandom_range(1, 0) != 0) ? RD : WR, pool[$urandom_range(7, 0)],
                  $urandom, 4'($urandom_range(15, 1)), a);
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid_read;
    int a;
    stall_en = 1'b0;
    lat_lo = 3; lat_hi = 3;
    master_op(1, RD, 32'h8010_0000, 32'h0, 4'hF, a);
    rst = 1'b1;
    exp_q_d.delete();
    m_cmd[1] = RD; m_addr[1] = 32'h0; m_ben[1] = 4'hF;
    @(negedge clk);
    vectors += 4;
    if (m_acc[1] !== 1'b0) begin
      errors++; $display("FAIL midrst_accept got=%b required=0", m_acc[1]);
    end
    if (m_sresp[1] !== 2'd0 || m_sdata[1] !== 32'h0) begin
      errors++; $display("FAIL midrst_resp got=%0d/%h required=0/0", m_sresp[1], m_sdata[1]);
    end
    if (p_mcmd[0] !== IDLE) begin
      errors++; $display("FAIL midrst_p0_mcmd got=%0d required=0", p_mcmd[0]);
    end
    if (p_mcmd[2] !== IDLE) begin
      errors++; $display("FAIL midrst_p2_mcmd got=%0d required=0", p_mcmd[2]);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    m_cmd[1] = IDLE; m_addr[1] = 32'h0; m_ben[1] = 4'h0;
    idle_cycles(6);
    lat_lo = 1; lat_hi = 3;
    master_op(1, RD, 32'h8010_0000, 32'h0, 4'hF, a);
    wait_drain();
  endtask

  // ---------------- sequence ----------------
  initial begin
    rst = 1'b1;
    for (int m = 0; m < 2; m++) begin
      m_cmd[m] = IDLE; m_addr[m] = 32'h0; m_data[m] = 32'h0; m_ben[m] = 4'h0;
      resp_cyc[m] = -1;
    end
    for (int n = 0; n < 5; n++) begin
      p_acc[n] = 1'b1; p_sresp[n] = 2'd0; p_sdata[n] = 32'h0;
      rsp_wait[n] = 0; rsp_val[n] = 32'h0;
      for (int w = 0; w < 16; w++) smem[n][w] = init_word(port_base(n) + 32'(w * 4));
    end
    #1;
    test_reset();
    test_owner_block();
    test_same_port_priority();
    test_parallel_ports();
    test_timer_ic();
    test_cross_read();
    test_unmapped();
    test_random();
    test_reset_mid_read();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
